// File: rtl/cpu_ctl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALU_op codes,
// FSM state codes and the datapath control word driven by mc_control_fsm.
package cpu_ctl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] pc_source;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctl_t;

   function automatic logic op_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: instruction/memory status in, datapath controls out.
// master = control FSM, slave = datapath side.
interface mc_control_fsm_if;
   import cpu_ctl_pkg::*;

   logic [5:0] Opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       ALUSrcA;
   logic       RegWrite;
   logic       RegDst;
   logic [1:0] PCSource;
   logic [1:0] ALUSrcB;
   logic [1:0] ALU_op;
   logic       illegal_op;
   logic       err_sticky;
   logic [3:0] state;

   modport master (
      input  Opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALU_op,
             illegal_op, err_sticky, state
   );

   modport slave (
      output Opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALU_op,
             illegal_op, err_sticky, state
   );

endinterface

// File: rtl/mc_ctl_decode.sv
// Pure combinational state -> control-word decode (Moore outputs, zero latency).
// Fetch write enables come out ungated; the top applies mem_ready and reset gating.
module mc_ctl_decode
   import cpu_ctl_pkg::*;
(
   input  state_t state,
   output ctl_t   cw
);

   always_comb begin
      cw = '0;
      case (state)
         S_FETCH: begin
            cw.mem_read  = 1'b1;
            cw.ir_write  = 1'b1;
            cw.pc_write  = 1'b1;
            cw.alu_src_b = 2'b01;
            cw.alu_op    = ALUOP_ADD;
         end
         S_DECODE: begin
            cw.alu_src_b = 2'b11;
            cw.alu_op    = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = 2'b10;
            cw.alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            cw.mem_read = 1'b1;
            cw.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            cw.reg_write  = 1'b1;
            cw.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            cw.mem_write = 1'b1;
            cw.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            cw.reg_write = 1'b1;
            cw.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            cw.alu_src_a     = 1'b1;
            cw.alu_op        = ALUOP_SUB;
            cw.pc_write_cond = 1'b1;
            cw.pc_source     = 2'b01;
         end
         S_JUMP: begin
            cw.pc_write  = 1'b1;
            cw.pc_source = 2'b10;
         end
         S_ADDIWB: begin
            cw.reg_write = 1'b1;
         end
         default: cw = '0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU main control FSM: 3-5 cycles per instruction with memory ready.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; reset gates every write enable.
module mc_control_fsm
   import cpu_ctl_pkg::*;
(
   input logic          clk,
   input logic          reset,
   mc_control_fsm_if.master bus
);

   state_t     state_q;
   state_t     state_d;
   state_t     dec_state;
   logic [5:0] op_q;
   logic       err_q;
   logic       illegal;
   logic       fetch_gate;
   logic       wen_ok;
   ctl_t       cw;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= bus.Opcode;
         if (illegal) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      illegal = 1'b0;
      case (state_q)
         S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         // op_q is only ever LW or SW here; IR may have moved on already
         S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // During reset the muxes show FETCH settings regardless of the abandoned state.
   assign dec_state  = reset ? S_FETCH : state_q;
   assign fetch_gate = (dec_state == S_FETCH) ? bus.mem_ready : 1'b1;
   assign wen_ok     = ~reset;

   mc_ctl_decode u_decode (
      .state (dec_state),
      .cw    (cw)
   );

   assign bus.PCWrite     = cw.pc_write & fetch_gate & wen_ok;
   assign bus.IRWrite     = cw.ir_write & fetch_gate & wen_ok;
   assign bus.PCWriteCond = cw.pc_write_cond & wen_ok;
   assign bus.MemWrite    = cw.mem_write & wen_ok;
   assign bus.RegWrite    = cw.reg_write & wen_ok;
   assign bus.IorD        = cw.i_or_d;
   assign bus.MemRead     = cw.mem_read;
   assign bus.MemtoReg    = cw.mem_to_reg;
   assign bus.ALUSrcA     = cw.alu_src_a;
   assign bus.RegDst      = cw.reg_dst;
   assign bus.PCSource    = cw.pc_source;
   assign bus.ALUSrcB     = cw.alu_src_b;
   assign bus.ALU_op      = cw.alu_op;
   assign bus.illegal_op  = illegal & wen_ok;
   assign bus.err_sticky  = err_q;
   assign bus.state       = state_q;

endmodule
